// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: control_in bit positions, MEM FSM encoding, TIMEOUT default and alignment rule shared by the MEM stage
package mem_stage_pkg;
  localparam int CTL_LB_LH = 7;
  localparam int CTL_MEM_READ = 6;
  localparam int CTL_MEM_WRITE = 5;
  localparam int CTL_HALF = 4;
  localparam int CTL_REG_WRITE = 3;
  localparam int CTL_MEM_TO_REG = 2;
  localparam int TIMEOUT_DEFAULT = 255;
  typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} mem_state_t;
  function automatic logic misaligned(input logic [7:0] ctl, input logic [1:0] addr);
    return ctl[CTL_LB_LH] ? ctl[CTL_HALF] & addr[0] : addr != 2'b00;
  endfunction
endpackage

// File: rtl/mem_stage_load_align.sv
// load_align: addr/rdata/sub/half in, result out; picks a big-endian half or byte lane and sign-extends, or passes the word
module load_align (
  input  logic [1:0]  addr,
  input  logic [31:0] rdata,
  input  logic        sub,
  input  logic        half,
  output logic [31:0] result
);
  logic [15:0] hw;
  logic [7:0] by;
  always_comb begin
    hw = addr[1] ? rdata[15:0] : rdata[31:16];
    by = addr[0] ? (addr[1] ? rdata[7:0] : rdata[23:16]) : (addr[1] ? rdata[15:8] : rdata[31:24]);
    result = !sub ? rdata : half ? {{16{hw[15]}}, hw} : {{24{by[7]}}, by};
  end
endmodule

// File: rtl/mem_stage.sv
// mem_stage: EX/MEM + MEM/WB pipeline stage; EX inputs -> stall/fwd_data, dmem_* request/ack port, wb_* outputs with mem_exc on misalign or timeout
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [31:0] pc_in,
  input  logic [31:0] alu_data,
  input  logic [31:0] rt_data,
  input  logic [4:0]  regdst,
  input  logic [7:0]  control_in,
  input  logic        flush,
  output logic        stall,
  output logic [31:0] fwd_data,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        wb_valid,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_rd,
  output logic        wb_reg_write,
  output logic [1:0]  wb_ctrl,
  output logic [31:0] wb_pc,
  output logic        mem_exc
);
  mem_state_t state, state_nx;
  logic [7:0] cnt;
  logic ex_valid;
  logic [31:0] ex_pc, ex_alu, ex_rt;
  logic [4:0] ex_rd;
  logic [7:0] ex_ctl;
  logic [31:0] load_res;
  logic is_mem, in_go, tmo, retire, exc_nx, valid_nx, rw_nx;
  load_align u_align (
    .addr(ex_alu[1:0]),
    .rdata(dmem_rdata),
    .sub(ex_ctl[CTL_LB_LH]),
    .half(ex_ctl[CTL_HALF]),
    .result(load_res)
  );
  assign is_mem = ex_ctl[CTL_MEM_READ] | ex_ctl[CTL_MEM_WRITE];
  assign in_go = in_valid && !flush && (control_in[CTL_MEM_READ] | control_in[CTL_MEM_WRITE]) && !misaligned(control_in, alu_data[1:0]);
  assign stall = (state == ACCESS) && !dmem_ack;
  assign tmo = stall && cnt == 8'(TIMEOUT - 1);
  assign dmem_req = state == ACCESS;
  assign dmem_we = dmem_req & ex_ctl[CTL_MEM_WRITE];
  assign dmem_addr = ex_alu;
  assign dmem_wdata = ex_rt;
  assign fwd_data = ex_alu;
  always_comb begin
    state_nx = !stall ? (in_go ? ACCESS : IDLE) : tmo ? IDLE : state;
    retire = !stall || tmo;
    valid_nx = retire && ex_valid;
    exc_nx = valid_nx && is_mem && (misaligned(ex_ctl, ex_alu[1:0]) || tmo);
    rw_nx = valid_nx && ex_ctl[CTL_REG_WRITE] && !exc_nx;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= 8'd0;
      ex_valid <= 1'b0;
      ex_pc <= 32'd0;
      ex_alu <= 32'd0;
      ex_rt <= 32'd0;
      ex_rd <= 5'd0;
      ex_ctl <= 8'd0;
      wb_valid <= 1'b0;
      wb_data <= 32'd0;
      wb_rd <= 5'd0;
      wb_reg_write <= 1'b0;
      wb_ctrl <= 2'd0;
      wb_pc <= 32'd0;
      mem_exc <= 1'b0;
    end else begin
      state <= state_nx;
      cnt <= stall ? cnt + 8'd1 : 8'd0;
      if (!stall) begin
        ex_valid <= in_valid && !flush;
        ex_pc <= pc_in;
        ex_alu <= alu_data;
        ex_rt <= rt_data;
        ex_rd <= regdst;
        ex_ctl <= control_in;
      end else if (tmo) ex_valid <= 1'b0;
      wb_valid <= valid_nx;
      wb_reg_write <= rw_nx;
      mem_exc <= exc_nx;
      if (retire) begin
        wb_data <= ex_ctl[CTL_MEM_TO_REG] ? load_res : ex_alu;
        wb_rd <= ex_rd;
        wb_ctrl <= ex_ctl[1:0];
        wb_pc <= ex_pc;
      end
    end
  end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed scenarios plus a randomized transaction-level scoreboard for mem_stage
module tb_mem_stage;
  localparam int TMO = 4;
  localparam logic [7:0] ALU = 8'b0000_1001;
  localparam logic [7:0] LW = 8'b0100_1100;
  localparam logic [7:0] LH = 8'b1101_1100;
  localparam logic [7:0] LB = 8'b1100_1100;
  localparam logic [7:0] SW = 8'b0010_0000;
  typedef struct {logic [31:0] pc, data; logic [4:0] rd; logic [1:0] ctrl; logic rw, exc;} exp_t;
  typedef struct {int d; logic [31:0] addr, wdata; logic we;} acc_t;
  logic clk = 0, rst_n = 0;
  logic in_valid, flush, dmem_ack, stall, dmem_req, dmem_we, wb_valid, wb_reg_write, mem_exc;
  logic [31:0] pc_in, alu_data, rt_data, fwd_data, dmem_addr, dmem_wdata, dmem_rdata, wb_data, wb_pc;
  logic [4:0] regdst, wb_rd;
  logic [7:0] control_in;
  logic [1:0] wb_ctrl;
  logic use_fixed = 0;
  logic [31:0] fixed_rdata = 0;
  int checks = 0, passes = 0;
  mem_stage #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .pc_in(pc_in), .alu_data(alu_data),
    .rt_data(rt_data), .regdst(regdst), .control_in(control_in), .flush(flush),
    .stall(stall), .fwd_data(fwd_data), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .wb_valid(wb_valid), .wb_data(wb_data), .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
    .wb_ctrl(wb_ctrl), .wb_pc(wb_pc), .mem_exc(mem_exc)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[31:2], 2'b00} * 32'h9E37_79B1 ^ 32'h5A5A_0F0F;
  endfunction
  function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [31:0] a, input logic sub, input logic half);
    logic [15:0] h;
    logic [7:0] b;
    if (!sub) return w;
    if (half) begin
      h = 16'(w >> (a[1] ? 0 : 16));
      return 32'($signed(h));
    end
    b = 8'(w >> (8 * (3 - int'(a[1:0]))));
    return 32'($signed(b));
  endfunction
  assign dmem_rdata = use_fixed ? fixed_rdata : mem_word(dmem_addr);
  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] a, input logic [31:0] rt,
                       input logic [4:0] rd, input logic [7:0] c, input logic f);
    in_valid = v; pc_in = pc; alu_data = a; rt_data = rt; regdst = rd; control_in = c; flush = f;
  endtask
  task automatic test_reset;
    rst_n = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if ({dmem_req, dmem_we, stall, wb_valid, wb_reg_write, mem_exc} !== 6'b0) $display("FAIL reset_flags got %b exp 000000", {dmem_req, dmem_we, stall, wb_valid, wb_reg_write, mem_exc}); else passes++;
    checks++; if ({fwd_data, wb_data, wb_pc, dmem_addr} !== 128'd0) $display("FAIL reset_data got %h %h %h %h exp 0", fwd_data, wb_data, wb_pc, dmem_addr); else passes++;
    rst_n = 1;
    @(negedge clk);
  endtask
  task automatic test_alu;
    drive(1, 32'h100, 32'h1234, 32'h0, 5'd5, ALU, 0);
    @(negedge clk);
    checks++; if (stall !== 1'b0 || fwd_data !== 32'h1234 || wb_valid !== 1'b0) $display("FAIL alu_capture got stall=%b fwd=%h wbv=%b exp 0 1234 0", stall, fwd_data, wb_valid); else passes++;
    drive(0, 0, 0, 0, 0, 8'h00, 0);
    @(negedge clk);
    checks++; if (wb_valid !== 1'b1 || wb_reg_write !== 1'b1 || wb_rd !== 5'd5) $display("FAIL alu_wb got v=%b rw=%b rd=%0d exp 1 1 5", wb_valid, wb_reg_write, wb_rd); else passes++;
    checks++; if (wb_data !== 32'h1234 || wb_pc !== 32'h100 || wb_ctrl !== 2'b01 || stall !== 1'b0) $display("FAIL alu_data got %h pc=%h ctrl=%b stall=%b exp 1234 100 01 0", wb_data, wb_pc, wb_ctrl, stall); else passes++;
    @(negedge clk);
    checks++; if (wb_valid !== 1'b0) $display("FAIL alu_bubble got %b exp 0", wb_valid); else passes++;
  endtask
  task automatic test_loads;
    logic [1:0] lo [6] = '{2'd3, 2'd2, 2'd0, 2'd1, 2'd0, 2'd0};
    logic [7:0] ct [6] = '{LB, LH, LH, LB, LW, LB};
    logic [31:0] rv [6] = '{32'h1122_33F0, 32'h1122_33F0, 32'h8122_33F0, 32'h11A2_33F0, 32'hDEAD_BEEF, 32'h7F00_0000};
    logic [31:0] ev [6] = '{32'hFFFF_FFF0, 32'h0000_33F0, 32'hFFFF_8122, 32'hFFFF_FFA2, 32'hDEAD_BEEF, 32'h0000_007F};
    use_fixed = 1;
    for (int i = 0; i < 6; i++) begin
      fixed_rdata = rv[i];
      drive(1, 32'h400 + 32'(i), {30'h400, lo[i]}, 32'h0, 5'd9, ct[i], 0);
      @(negedge clk);
      checks++; if (dmem_req !== 1'b1 || dmem_we !== 1'b0 || dmem_addr !== {30'h400, lo[i]}) $display("FAIL load_req[%0d] got req=%b we=%b addr=%h", i, dmem_req, dmem_we, dmem_addr); else passes++;
      drive(0, 0, 0, 0, 0, 8'h00, 0);
      dmem_ack = 1;
      @(negedge clk);
      dmem_ack = 0;
      checks++; if (wb_valid !== 1'b1 || wb_reg_write !== 1'b1 || mem_exc !== 1'b0 || wb_data !== ev[i]) $display("FAIL load_data[%0d] got v=%b rw=%b exc=%b data=%h exp 1 1 0 %h", i, wb_valid, wb_reg_write, mem_exc, wb_data, ev[i]); else passes++;
    end
    use_fixed = 0;
  endtask
  task automatic test_store_wait;
    int nreq = 0, nstall = 0, bad = 0;
    drive(1, 32'h200, 32'h2000, 32'hCAFE_BABE, 5'd0, SW, 0);
    @(negedge clk);
    drive(1, 32'h204, 32'h77, 32'h0, 5'd7, ALU, 0);
    for (int i = 0; i < 4; i++) begin
      dmem_ack = (i == 3);
      #1;
      if (dmem_req) nreq++;
      if (stall) nstall++;
      if (dmem_req && (dmem_addr !== 32'h2000 || dmem_wdata !== 32'hCAFE_BABE || dmem_we !== 1'b1)) bad++;
      if (fwd_data !== 32'h2000) bad++;
      @(negedge clk);
    end
    dmem_ack = 0;
    checks++; if (nreq != 4 || nstall != 3) $display("FAIL store_wait got req=%0d stall=%0d exp 4 3", nreq, nstall); else passes++;
    checks++; if (bad != 0) $display("FAIL store_hold got %0d unstable cycles exp 0", bad); else passes++;
    checks++; if (wb_valid !== 1'b1 || wb_pc !== 32'h200 || wb_reg_write !== 1'b0 || mem_exc !== 1'b0 || dmem_req !== 1'b0) $display("FAIL store_retire got v=%b pc=%h rw=%b exc=%b req=%b", wb_valid, wb_pc, wb_reg_write, mem_exc, dmem_req); else passes++;
    checks++; if (fwd_data !== 32'h77) $display("FAIL store_next_accept got %h exp 77", fwd_data); else passes++;
    drive(0, 0, 0, 0, 0, 8'h00, 0);
    @(negedge clk);
    checks++; if (wb_valid !== 1'b1 || wb_rd !== 5'd7 || wb_data !== 32'h77 || wb_pc !== 32'h204) $display("FAIL store_next_wb got v=%b rd=%0d data=%h pc=%h", wb_valid, wb_rd, wb_data, wb_pc); else passes++;
  endtask
  task automatic test_misaligned;
    logic [7:0] ct [2] = '{LW, LH};
    logic [31:0] ad [2] = '{32'h3002, 32'h3001};
    for (int i = 0; i < 2; i++) begin
      drive(1, 32'h300, ad[i], 32'h0, 5'd4, ct[i], 0);
      @(negedge clk);
      drive(0, 0, 0, 0, 0, 8'h00, 0);
      checks++; if (dmem_req !== 1'b0 || stall !== 1'b0) $display("FAIL mis_noreq[%0d] got req=%b stall=%b exp 0 0", i, dmem_req, stall); else passes++;
      @(negedge clk);
      checks++; if (wb_valid !== 1'b1 || mem_exc !== 1'b1 || wb_reg_write !== 1'b0) $display("FAIL mis_exc[%0d] got v=%b exc=%b rw=%b exp 1 1 0", i, wb_valid, mem_exc, wb_reg_write); else passes++;
      @(negedge clk);
      checks++; if (mem_exc !== 1'b0 || wb_valid !== 1'b0) $display("FAIL mis_pulse[%0d] got exc=%b v=%b exp 0 0", i, mem_exc, wb_valid); else passes++;
    end
  endtask
  task automatic test_timeout;
    int n = 0;
    drive(1, 32'h500, 32'h4000, 32'h0, 5'd3, LW, 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 8'h00, 0);
    for (int i = 0; i < 10; i++) begin
      if (mem_exc) break;
      if (dmem_req) n++;
      @(negedge clk);
    end
    checks++; if (mem_exc !== 1'b1 || n != TMO) $display("FAIL timeout got exc=%b req_cycles=%0d exp 1 %0d", mem_exc, n, TMO); else passes++;
    checks++; if (dmem_req !== 1'b0 || stall !== 1'b0 || wb_valid !== 1'b1 || wb_reg_write !== 1'b0) $display("FAIL timeout_retire got req=%b stall=%b v=%b rw=%b exp 0 0 1 0", dmem_req, stall, wb_valid, wb_reg_write); else passes++;
    @(negedge clk);
    checks++; if (mem_exc !== 1'b0 || wb_valid !== 1'b0 || dmem_req !== 1'b0) $display("FAIL timeout_idle got exc=%b v=%b req=%b exp 0 0 0", mem_exc, wb_valid, dmem_req); else passes++;
  endtask
  task automatic test_ack_last;
    drive(1, 32'h600, 32'h5000, 32'h0, 5'd6, LW, 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 8'h00, 0);
    for (int i = 0; i < TMO; i++) begin
      dmem_ack = (i == TMO - 1);
      @(negedge clk);
    end
    dmem_ack = 0;
    checks++; if (wb_valid !== 1'b1 || mem_exc !== 1'b0 || wb_reg_write !== 1'b1 || wb_data !== mem_word(32'h5000)) $display("FAIL ack_last got v=%b exc=%b rw=%b data=%h exp 1 0 1 %h", wb_valid, mem_exc, wb_reg_write, wb_data, mem_word(32'h5000)); else passes++;
  endtask
  task automatic test_reset_mid;
    drive(1, 32'h700, 32'h6000, 32'h0, 5'd8, LW, 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 8'h00, 0);
    @(negedge clk);
    checks++; if (dmem_req !== 1'b1) $display("FAIL rmid_access got req=%b exp 1", dmem_req); else passes++;
    rst_n = 0;
    dmem_ack = 1;
    drive(1, 32'h704, 32'h6004, 32'h0, 5'd8, LW, 1);
    @(negedge clk);
    dmem_ack = 0;
    #1;
    checks++; if ({dmem_req, dmem_we, stall, wb_valid, wb_reg_write, mem_exc} !== 6'b0) $display("FAIL rmid_flags got %b exp 000000", {dmem_req, dmem_we, stall, wb_valid, wb_reg_write, mem_exc}); else passes++;
    checks++; if ({fwd_data, wb_data, dmem_addr} !== 96'd0) $display("FAIL rmid_data got %h %h %h exp 0", fwd_data, wb_data, dmem_addr); else passes++;
    rst_n = 1;
    drive(0, 0, 0, 0, 0, 8'h00, 0);
    @(negedge clk);
    checks++; if (dmem_req !== 1'b0 || stall !== 1'b0 || wb_valid !== 1'b0) $display("FAIL rmid_idle got req=%b stall=%b v=%b exp 0 0 0", dmem_req, stall, wb_valid); else passes++;
  endtask
  task automatic test_random;
    exp_t exp_q [$];
    acc_t acc_q [$];
    exp_t e;
    acc_t ca = '{0, 32'd0, 32'd0, 1'b0};
    logic v = 0, f = 0, need_new = 1, mem, mis;
    logic [31:0] pc = 32'h1000, a = 0, rt = 0, last_alu = 0;
    logic [4:0] rd = 0;
    logic [7:0] c = 0;
    int k = 0, d, kind;
    for (int cyc = 0; cyc < 640; cyc++) begin
      checks++; if (fwd_data !== last_alu) $display("FAIL rnd_fwd got %h exp %h", fwd_data, last_alu); else passes++;
      if (wb_valid) begin
        checks++;
        if (exp_q.size() == 0) $display("FAIL rnd_spurious got wb_valid=1 pc=%h exp no retire", wb_pc);
        else begin
          e = exp_q.pop_front();
          if (wb_pc !== e.pc || wb_rd !== e.rd || wb_ctrl !== e.ctrl || wb_reg_write !== e.rw || mem_exc !== e.exc || (!e.exc && wb_data !== e.data))
            $display("FAIL rnd_wb got pc=%h rd=%0d ctrl=%b rw=%b exc=%b data=%h exp pc=%h rd=%0d ctrl=%b rw=%b exc=%b data=%h",
                     wb_pc, wb_rd, wb_ctrl, wb_reg_write, mem_exc, wb_data, e.pc, e.rd, e.ctrl, e.rw, e.exc, e.data);
          else passes++;
        end
      end else begin
        checks++; if (mem_exc !== 1'b0 || wb_reg_write !== 1'b0) $display("FAIL rnd_bubble got exc=%b rw=%b exp 0 0", mem_exc, wb_reg_write); else passes++;
      end
      if (dmem_req) begin
        if (k == 0) begin
          checks++;
          if (acc_q.size() == 0) begin
            $display("FAIL rnd_req got unexpected request addr=%h exp none", dmem_addr);
            ca = '{0, dmem_addr, dmem_wdata, dmem_we};
          end else begin
            ca = acc_q.pop_front();
            passes++;
          end
        end
        checks++; if (dmem_addr !== ca.addr || dmem_we !== ca.we || (ca.we && dmem_wdata !== ca.wdata)) $display("FAIL rnd_port got addr=%h we=%b wd=%h exp %h %b %h", dmem_addr, dmem_we, dmem_wdata, ca.addr, ca.we, ca.wdata); else passes++;
        dmem_ack = (k == ca.d);
        k = (k == ca.d || k == TMO - 1) ? 0 : k + 1;
      end else begin
        checks++; if (acc_q.size() != 0) $display("FAIL rnd_issue got req=0 exp pending access addr=%h", acc_q[0].addr); else passes++;
        dmem_ack = $urandom_range(0, 7) == 0;
        k = 0;
      end
      if (need_new) begin
        pc = pc + 4; a = $urandom; rt = $urandom; rd = 5'($urandom);
        v = cyc < 600 && $urandom_range(0, 9) != 0;
        kind = $urandom_range(0, 4);
        c = kind == 0 ? ALU : kind == 1 ? LW : kind == 2 ? LH : kind == 3 ? LB : SW;
        c[1:0] = 2'($urandom);
        if (kind == 0) c[3] = 1'($urandom);
        if (kind != 0 && kind != 3 && $urandom_range(0, 2) != 0) a[1:0] = 2'b00;
      end
      f = $urandom_range(0, 6) == 0;
      drive(v, pc, a, rt, rd, c, f);
      #1;
      if (!stall) begin
        last_alu = a;
        if (v && !f) begin
          mem = c[6] | c[5];
          mis = mem && (c[7] ? (c[4] && a[0]) : (a[1:0] != 2'b00));
          d = $urandom_range(0, 9) < 8 ? $urandom_range(0, TMO - 1) : $urandom_range(TMO, TMO + 2);
          e.pc = pc; e.rd = rd; e.ctrl = c[1:0];
          e.exc = mis || (mem && d >= TMO);
          e.rw = c[3] && !e.exc;
          e.data = c[2] ? ref_load(mem_word(a), a, c[7], c[4]) : a;
          exp_q.push_back(e);
          if (mem && !mis) acc_q.push_back('{d, a, rt, c[5]});
        end
        need_new = 1;
      end else need_new = 0;
      @(negedge clk);
    end
    dmem_ack = 0;
    checks++; if (exp_q.size() != 0 || acc_q.size() != 0) $display("FAIL rnd_drain got %0d retires %0d accesses pending exp 0 0", exp_q.size(), acc_q.size()); else passes++;
  endtask
  initial begin
    drive(0, 0, 0, 0, 0, 8'h00, 0);
    dmem_ack = 0;
    test_reset;
    test_alu;
    test_loads;
    test_store_wait;
    test_misaligned;
    test_timeout;
    test_ack_last;
    test_reset_mid;
    test_random;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL watchdog got no finish by 100000 exp finish");
    $fatal(1, "watchdog");
  end
endmodule
